// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-side datapath.
package mips_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_VALID,
    IFU_HALT
  } ifu_state_t;

  // 4-bit increment that sticks at its maximum instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ifu_byte_assembler.sv
// Shift-in byte lane register: little-endian bytes arrive lowest first and
// are shifted in from the top, so after four shifts the word is {b3,b2,b1,b0}.
module ifu_byte_assembler
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_nxt_o,
  output logic               last_o
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_INSTR);

  logic [INSTR_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Word as it will look once the current byte is shifted in; the top
  // registers this on the final byte so no partial word ever escapes.
  assign word_nxt_o = {byte_i, word_q[INSTR_W-1:8]};
  assign last_o     = shift_i && (idx_q == IDX_W'(BYTES_PER_INSTR - 1));

  // Next-state: clear outranks shift so a discarded fetch leaves nothing behind.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = word_nxt_o;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  // Lane and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads four bytes per instruction from a
// 1-cycle-latency imem, offers the word to decode via valid/ready, follows
// redirects and halts after a run of consecutive NOPs.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned RESET_PC       = 0,
  parameter int unsigned NOP_HALT_COUNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rd_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              halted
);

  ifu_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [2:0]         iss_q, iss_d;
  logic               pend_q, pend_d;
  logic [3:0]         nop_q, nop_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;

  logic               issue;
  logic               xfer;
  logic               nop_hit;
  logic [3:0]         nop_inc;
  logic               halt_now;
  logic [ADDR_W-1:0]  redir_pc;
  logic               asm_clr;
  logic               asm_last;
  logic [INSTR_W-1:0] asm_word;
  logic               unused_redirect_bits;

  assign redir_pc             = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_bits = ^{redirect_pc[31:ADDR_W], redirect_pc[1:0]};

  assign issue      = (state_q == IFU_FETCH) && (iss_q < 3'd4);
  assign imem_rd_en = issue;
  assign imem_addr  = issue ? pc_q + ADDR_W'(iss_q[1:0]) : '0;

  assign xfer     = (state_q == IFU_VALID) && instr_ready;
  assign nop_hit  = (instr_q == NOP_INSTR);
  assign nop_inc  = sat_inc4(nop_q);
  assign halt_now = xfer && nop_hit && (nop_inc >= 4'(NOP_HALT_COUNT));

  // Anything outside an active fetch, or a redirect, throws away partial bytes.
  assign asm_clr = (state_q != IFU_FETCH) || redirect_valid;

  ifu_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (asm_clr),
    .shift_i    (pend_q),
    .byte_i     (imem_rd_data),
    .word_nxt_o (asm_word),
    .last_o     (asm_last)
  );

  assign instr_valid = (state_q == IFU_VALID);
  assign halted      = (state_q == IFU_HALT);
  assign instr       = instr_q;
  assign instr_pc    = 32'(ipc_q);

  // Fetch FSM next-state; pend tracks which cycles carry returned read data.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iss_d   = iss_q;
    pend_d  = 1'b0;
    nop_d   = nop_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_FETCH;
        iss_d   = '0;
        if (redirect_valid) pc_d = redir_pc;
      end
      IFU_FETCH: begin
        if (redirect_valid) begin
          pc_d  = redir_pc;
          iss_d = '0;
        end else begin
          pend_d = issue;
          if (issue) iss_d = iss_q + 3'd1;
          if (asm_last) begin
            instr_d = asm_word;
            ipc_d   = pc_q;
            state_d = IFU_VALID;
          end
        end
      end
      IFU_VALID: begin
        // A coincident redirect still lets this transfer complete; only the
        // follow-on PC changes, and a NOP-run halt takes precedence.
        if (xfer) begin
          nop_d = nop_hit ? nop_inc : '0;
          iss_d = '0;
          pc_d  = redirect_valid ? redir_pc : pc_q + ADDR_W'(BYTES_PER_INSTR);
          state_d = halt_now ? IFU_HALT : IFU_FETCH;
        end else if (redirect_valid) begin
          pc_d    = redir_pc;
          iss_d   = '0;
          state_d = IFU_FETCH;
        end
      end
      IFU_HALT: begin
        state_d = IFU_HALT;
      end
      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFU_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      iss_q   <= '0;
      pend_q  <= 1'b0;
      nop_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iss_q   <= iss_d;
      pend_q  <= pend_d;
      nop_q   <= nop_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 1-cycle imem.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;

  logic [7:0] mem [0:255];
  int total = 0;
  int bad   = 0;
  int rd_total   = 0;
  int xfer_total = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W         (8),
    .RESET_PC       (0),
    .NOP_HALT_COUNT (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  // Memory model plus free-running read and transfer counters.
  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_rd_data <= mem[imem_addr];
      rd_total     <= rd_total + 1;
    end
    if (instr_valid && instr_ready) xfer_total <= xfer_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + k] = w[8*k +: 8];
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    chk({tag, "_rst_rd_en"}, 32'(imem_rd_en), 32'd0);
    chk({tag, "_rst_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_rst_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_rst_instr"}, instr, 32'd0);
    chk({tag, "_rst_pc"},    instr_pc, 32'd0);
    chk({tag, "_rst_halt"},  32'(halted), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!instr_valid && n < 60) begin
      step();
      n++;
    end
    if (!instr_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_read(input string tag, input logic [7:0] a);
    int n = 0;
    while (!(imem_rd_en && imem_addr == a) && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_read_seen"}, 32'(imem_addr), 32'(a));
  endtask

  initial begin
    int n;
    int r0;
    int x0;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    fill();

    // 1: basic fetch, latency and next sequential word
    mem[0] = 8'h0a; mem[1] = 8'h00; mem[2] = 8'h0a; mem[3] = 8'h20;
    put_word(4, 32'hCAFE_0001);
    instr_ready = 1'b1;
    do_reset("t1");
    wait_valid("t1a", n);
    chk("t1_latency", n, 32'd6);
    chk("t1_instr", instr, 32'h200A_000A);
    chk("t1_pc", instr_pc, 32'd0);
    step();
    wait_valid("t1b", n);
    chk("t1_latency2", n, 32'd5);
    chk("t1_instr2", instr, 32'hCAFE_0001);
    chk("t1_pc2", instr_pc, 32'd4);

    // 2: decode stall holds the word and blocks reads
    instr_ready = 1'b0;
    do_reset("t2");
    wait_valid("t2a", n);
    r0 = rd_total;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
      chk("t2_hold_instr", instr, 32'h200A_000A);
      chk("t2_hold_pc", instr_pc, 32'd0);
      chk("t2_hold_rd_en", 32'(imem_rd_en), 32'd0);
    end
    chk("t2_hold_reads", rd_total - r0, 32'd0);
    instr_ready = 1'b1;
    step();
    chk("t2_resume_rd_en", 32'(imem_rd_en), 32'd1);
    chk("t2_resume_addr", 32'(imem_addr), 32'd4);
    wait_valid("t2b", n);
    chk("t2_next_pc", instr_pc, 32'd4);

    // 3: three NOPs halt; redirect in HALT is ignored
    fill();
    put_word(0, 32'h1234_5678);
    put_word(4, 32'h0);
    put_word(8, 32'h0);
    put_word(12, 32'h0);
    instr_ready = 1'b1;
    do_reset("t3");
    r0 = rd_total;
    x0 = xfer_total;
    n = 0;
    while (!halted && n < 200) begin
      step();
      n++;
    end
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_xfers", xfer_total - x0, 32'd4);
    chk("t3_reads", rd_total - r0, 32'd16);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_rd_en", 32'(imem_rd_en), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    repeat (5) step();
    chk("t3_halt_sticky", 32'(halted), 32'd1);
    chk("t3_no_reads", rd_total - r0, 32'd16);
    chk("t3_valid_after", 32'(instr_valid), 32'd0);

    // 4: redirect mid-fetch discards the partial word
    fill();
    put_word(0, 32'hAABB_CCDD);
    put_word(8'h40, 32'h0102_0304);
    instr_ready = 1'b1;
    do_reset("t4");
    wait_read("t4", 8'h02);
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("t4_no_valid", 32'(instr_valid), 32'd0);
    wait_valid("t4", n);
    chk("t4_latency", n, 32'd5);
    chk("t4_pc", instr_pc, 32'h40);
    chk("t4_instr", instr, 32'h0102_0304);

    // 5: redirect to top of memory, PC wraps to 0
    fill();
    put_word(8'hFC, 32'h89AB_CDEF);
    put_word(0, 32'h1357_9BDF);
    instr_ready = 1'b1;
    do_reset("t5");
    redirect_valid = 1'b1;
    redirect_pc = 32'h1234_01FD;
    step();
    redirect_valid = 1'b0;
    wait_valid("t5a", n);
    chk("t5_latency", n, 32'd5);
    chk("t5_pc_fc", instr_pc, 32'hFC);
    chk("t5_instr_fc", instr, 32'h89AB_CDEF);
    step();
    wait_valid("t5b", n);
    chk("t5_pc_wrap", instr_pc, 32'h0);
    chk("t5_instr_wrap", instr, 32'h1357_9BDF);

    // 7: redirect coincident with transfer delivers the word, then jumps
    put_word(8'h80, 32'h0BAD_F00D);
    x0 = xfer_total;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("t7_xfer", xfer_total - x0, 32'd1);
    wait_valid("t7", n);
    chk("t7_latency", n, 32'd5);
    chk("t7_pc", instr_pc, 32'h80);
    chk("t7_instr", instr, 32'h0BAD_F00D);

    // 6: reset mid-fetch clears the NOP counter
    fill();
    put_word(0, 32'h0);
    put_word(4, 32'h0);
    put_word(8, 32'h0);
    instr_ready = 1'b1;
    do_reset("t6a");
    wait_valid("t6a", n);
    chk("t6_first_nop", instr, 32'h0);
    step();
    wait_valid("t6b", n);
    chk("t6_second_pc", instr_pc, 32'd4);
    step();
    wait_read("t6", 8'h09);
    do_reset("t6mid");
    wait_valid("t6c", n);
    chk("t6_refetch_latency", n, 32'd6);
    chk("t6_refetch_pc", instr_pc, 32'd0);
    step();
    chk("t6_no_halt1", 32'(halted), 32'd0);
    wait_valid("t6d", n);
    chk("t6_pc4", instr_pc, 32'd4);
    step();
    chk("t6_no_halt2", 32'(halted), 32'd0);
    wait_valid("t6e", n);
    chk("t6_pc8", instr_pc, 32'd8);
    step();
    chk("t6_halt_third", 32'(halted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
